// File: rtl/agnus_bank_switcher_if.sv
// Agnus register-bus snoop and bank-select signal bundle for agnus_bank_switcher.
interface agnus_bank_switcher_if #(
  parameter int unsigned NUM_BANKS = 8
);
  logic [7:0]           rga;
  logic [15:0]          drdi;
  logic [15:0]          drdo;
  logic                 drd_oe;
  logic [NUM_BANKS-1:0] banksel;
  logic                 busy;
  logic [3:0]           led;

  modport master (
    output rga, drdi,
    input  drdo, drd_oe, banksel, busy, led
  );

  modport slave (
    input  rga, drdi,
    output drdo, drd_oe, banksel, busy, led
  );
endinterface

// File: rtl/agnus_bank_switcher.sv
// Chip-RAM bank switcher decoding BANKC/CONFIG/STATUS on the Agnus register bus.
// Optional break-before-make sequencer enabled by defining BREAK_BEFORE_MAKE_EN.
module agnus_bank_switcher #(
  parameter int unsigned NUM_BANKS = 8,
  parameter bit          BANK_1MB  = 1'b0,
  parameter int unsigned GUARD_CYC = 2
) (
  input logic                  cck,
  input logic                  rst_n,
  agnus_bank_switcher_if.slave bus
);

  localparam logic [7:0] AddrBankc  = 8'hF8;
  localparam logic [7:0] AddrConfig = 8'hFA;
  localparam logic [7:0] AddrStatus = 8'hFB;
  localparam logic [3:0] OpDs = 4'd0;
  localparam logic [3:0] OpCn = 4'd2;
  localparam logic [3:0] OpRp = 4'd6;

`ifdef BREAK_BEFORE_MAKE_EN
  localparam bit BbmEn = 1'b1;
`else
  localparam bit BbmEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StActive, StBreak} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  tgt_q, tgt_d;
  logic        tgt_vld_q, tgt_vld_d;
  logic        lock_q, lock_d;
  logic        err_q, err_d;
  logic        wr_pend_q;
  logic        sts_rd_q;
  logic        drd_oe_q;
  logic [15:0] drdo_q;

  logic        busy;
  logic        hit_bankc, hit_config, hit_status;
  logic [3:0]  cmd_op, cmd_bank;
  logic        in_range;
  logic        connect, disconnect, err_set;
  logic [15:0] status_word, config_word;
  logic        unused_drdi;

  assign hit_bankc  = (bus.rga == AddrBankc);
  assign hit_config = (bus.rga == AddrConfig);
  assign hit_status = (bus.rga == AddrStatus);

  assign cmd_op      = bus.drdi[3:0];
  assign cmd_bank    = bus.drdi[7:4];
  assign in_range    = (32'(cmd_bank) < NUM_BANKS);
  assign unused_drdi = ^bus.drdi[15:8];

`ifdef BREAK_BEFORE_MAKE_EN
  assign busy = (state_q == StBreak);
`else
  assign busy = 1'b0;
`endif

  assign status_word = {4'b0000, tgt_vld_q, err_q, busy, lock_q, tgt_q, op_q};
  assign config_word = {9'b0, BbmEn, BANK_1MB, 5'(NUM_BANKS - 1)};

  // Slot pipeline: address captured at E0, write data / read drop at E1.
  always_ff @(posedge cck or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend_q <= 1'b0;
      sts_rd_q  <= 1'b0;
      drd_oe_q  <= 1'b0;
      drdo_q    <= 16'h0000;
    end else begin
      wr_pend_q <= hit_bankc;
      sts_rd_q  <= hit_status;
      drd_oe_q  <= hit_config | hit_status;
      drdo_q    <= hit_config ? config_word :
                   hit_status ? status_word : 16'h0000;
    end
  end

  always_ff @(posedge cck or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      op_q      <= OpDs;
      tgt_q     <= 4'd0;
      tgt_vld_q <= 1'b0;
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      tgt_q     <= tgt_d;
      tgt_vld_q <= tgt_vld_d;
      lock_q    <= lock_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    tgt_d      = tgt_q;
    tgt_vld_d  = tgt_vld_q;
    lock_d     = lock_q;
    err_d      = err_q;
    connect    = 1'b0;
    disconnect = 1'b0;
    err_set    = 1'b0;

    if (wr_pend_q) begin
      if (cmd_op == OpCn && lock_q) begin
        err_set = 1'b1;
      end else if ((cmd_op == OpCn || cmd_op == OpRp) && in_range) begin
        op_d      = cmd_op;
        tgt_d     = cmd_bank;
        tgt_vld_d = 1'b1;
        connect   = 1'b1;
        if (cmd_op == OpRp) lock_d = 1'b1;
      end else begin
        // Unknown opcodes and out-of-range banks both fall back to DSBNK.
        op_d       = OpDs;
        tgt_d      = 4'd0;
        tgt_vld_d  = 1'b0;
        lock_d     = 1'b0;
        disconnect = 1'b1;
        if (cmd_op == OpCn || cmd_op == OpRp) err_set = 1'b1;
      end
    end

    if (sts_rd_q) err_d = 1'b0;
    if (err_set)  err_d = 1'b1;

    if (disconnect) begin
      state_d = StIdle;
    end else if (connect) begin
      if (!(state_q == StActive && tgt_q == cmd_bank)) begin
        if (BbmEn) begin
          state_d = StBreak;
          cnt_d   = 4'(GUARD_CYC - 1);
        end else begin
          state_d = StActive;
        end
      end
    end else if (state_q == StBreak) begin
      if (cnt_q == 4'd0) state_d = StActive;
      else               cnt_d   = cnt_q - 4'd1;
    end
  end

  assign bus.banksel = (state_q == StActive) ? ~(NUM_BANKS'(1) << tgt_q) : '1;
  assign bus.busy    = busy;
  assign bus.drd_oe  = drd_oe_q;
  assign bus.drdo    = drdo_q;
  assign bus.led     = {lock_q, tgt_vld_q, (state_q == StIdle), rst_n};

endmodule

// File: tb/tb_agnus_bank_switcher.sv
// Directed self-checking bench for agnus_bank_switcher (NUM_BANKS=8 and 16 instances).
module tb_agnus_bank_switcher;

  logic cck = 1'b0;
  logic rst_n = 1'b0;
  always #5 cck = ~cck;

`ifdef BREAK_BEFORE_MAKE_EN
  localparam bit Bbm = 1'b1;
`else
  localparam bit Bbm = 1'b0;
`endif

  agnus_bank_switcher_if #(.NUM_BANKS(8))  bus0 ();
  agnus_bank_switcher_if #(.NUM_BANKS(16)) bus1 ();

  agnus_bank_switcher #(.NUM_BANKS(8), .BANK_1MB(1'b0), .GUARD_CYC(2)) dut0 (
    .cck   (cck),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  agnus_bank_switcher #(.NUM_BANKS(16), .BANK_1MB(1'b1), .GUARD_CYC(3)) dut1 (
    .cck   (cck),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int checks = 0;
  int failures = 0;

  task automatic idle(input int n);
    repeat (n) @(negedge cck);
  endtask

  // Ends half a cycle after E1.
  task automatic wr(input logic [15:0] d);
    @(negedge cck); bus0.rga = 8'hF8;
    @(negedge cck); bus0.rga = 8'h00; bus0.drdi = d;
    @(negedge cck); bus0.drdi = 16'h0000;
  endtask

  task automatic rd(input logic [7:0] a, output logic [15:0] d, output logic oe,
                    output logic [15:0] d2, output logic oe2);
    @(negedge cck); bus0.rga = a;
    @(negedge cck); bus0.rga = 8'h00; d = bus0.drdo; oe = bus0.drd_oe;
    @(negedge cck); d2 = bus0.drdo; oe2 = bus0.drd_oe;
  endtask

  task automatic test_reset;
    bus0.rga = 8'h00; bus0.drdi = 16'h0000;
    bus1.rga = 8'h00; bus1.drdi = 16'h0000;
    idle(2);
    checks++; if (bus0.banksel !== 8'hFF) begin failures++;
      $display("FAIL reset_banksel got %h want ff", bus0.banksel); end
    checks++; if ({bus0.drd_oe, bus0.busy, bus0.drdo} !== 18'h0) begin failures++;
      $display("FAIL reset_outs got oe=%b busy=%b drdo=%h want 0", bus0.drd_oe, bus0.busy,
               bus0.drdo); end
    checks++; if (bus0.led !== 4'b0010) begin failures++;
      $display("FAIL reset_led got %b want 0010", bus0.led); end
    rst_n = 1'b1;
    idle(2);
    checks++; if (bus0.led !== 4'b0011) begin failures++;
      $display("FAIL post_reset_led got %b want 0011", bus0.led); end
  endtask

  task automatic test_connect;
    logic [15:0] d, d2; logic oe, oe2;
    wr(16'h0032);
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus0.banksel !== (Bbm ? 8'hFF : 8'hF7) || bus0.busy !== Bbm) begin
        failures++;
        $display("FAIL connect_gap%0d got sel=%h busy=%b want sel=%h busy=%b", i,
                 bus0.banksel, bus0.busy, Bbm ? 8'hFF : 8'hF7, Bbm); end
      idle(1);
    end
    checks++; if (bus0.banksel !== 8'hF7 || bus0.busy !== 1'b0) begin failures++;
      $display("FAIL connect_final got sel=%h busy=%b want f7 0", bus0.banksel, bus0.busy); end
    checks++; if (bus0.led !== 4'b0101) begin failures++;
      $display("FAIL connect_led got %b want 0101", bus0.led); end
    rd(8'hFB, d, oe, d2, oe2);
    checks++; if (d !== 16'h0832 || oe !== 1'b1) begin failures++;
      $display("FAIL connect_status got %h oe=%b want 0832 1", d, oe); end
    checks++; if (d2 !== 16'h0000 || oe2 !== 1'b0) begin failures++;
      $display("FAIL status_drop got %h oe=%b want 0000 0", d2, oe2); end
  endtask

  task automatic test_switch;
    wr(16'h0052);
    checks++; if (bus0.banksel !== (Bbm ? 8'hFF : 8'hDF)) begin failures++;
      $display("FAIL switch_first got %h want %h", bus0.banksel, Bbm ? 8'hFF : 8'hDF); end
    idle(2);
    checks++; if (bus0.banksel !== 8'hDF) begin failures++;
      $display("FAIL switch_final got %h want df", bus0.banksel); end
    wr(16'h0052);
    checks++; if (bus0.banksel !== 8'hDF || bus0.busy !== 1'b0) begin failures++;
      $display("FAIL rewrite_same got sel=%h busy=%b want df 0", bus0.banksel, bus0.busy); end
  endtask

  task automatic test_lock;
    logic [15:0] d, d2; logic oe, oe2;
    wr(16'h0016);
    idle(2);
    checks++; if (bus0.banksel !== 8'hFD) begin failures++;
      $display("FAIL lock_connect got %h want fd", bus0.banksel); end
    wr(16'h0042);
    idle(2);
    checks++; if (bus0.banksel !== 8'hFD || bus0.busy !== 1'b0) begin failures++;
      $display("FAIL lock_ignore got sel=%h busy=%b want fd 0", bus0.banksel, bus0.busy); end
    rd(8'hFB, d, oe, d2, oe2);
    checks++; if (d !== 16'h0D16) begin failures++;
      $display("FAIL lock_status_err got %h want 0d16", d); end
    rd(8'hFB, d, oe, d2, oe2);
    checks++; if (d !== 16'h0916) begin failures++;
      $display("FAIL lock_err_cleared got %h want 0916", d); end
  endtask

  task automatic test_range;
    logic [15:0] d, d2; logic oe, oe2;
    wr(16'h0000);
    checks++; if (bus0.banksel !== 8'hFF) begin failures++;
      $display("FAIL dsbnk got %h want ff", bus0.banksel); end
    wr(16'h00A2);
    checks++; if (bus0.banksel !== 8'hFF || bus0.led[1] !== 1'b1) begin failures++;
      $display("FAIL range_sel got sel=%h idle=%b want ff 1", bus0.banksel, bus0.led[1]); end
    rd(8'hFB, d, oe, d2, oe2);
    checks++; if ((d & 16'h0F00) !== 16'h0400) begin failures++;
      $display("FAIL range_status got %h want [11:8]=4", d); end
    wr(16'h0022);
    idle(2);
    checks++; if (bus0.banksel !== 8'hFB) begin failures++;
      $display("FAIL bank2 got %h want fb", bus0.banksel); end
    wr(16'h0025);
    checks++; if (bus0.banksel !== 8'hFF || bus0.busy !== 1'b0) begin failures++;
      $display("FAIL bad_op got sel=%h busy=%b want ff 0", bus0.banksel, bus0.busy); end
    rd(8'hFB, d, oe, d2, oe2);
    checks++; if ((d & 16'h0F00) !== 16'h0000) begin failures++;
      $display("FAIL bad_op_status got %h want [11:8]=0", d); end
  endtask

  task automatic test_config;
    logic [15:0] d, d2; logic oe, oe2;
    rd(8'hFA, d, oe, d2, oe2);
    checks++; if (d !== (16'h0007 | (16'(Bbm) << 6)) || oe !== 1'b1) begin failures++;
      $display("FAIL config8 got %h oe=%b want %h 1", d, oe, 16'h0007 | (16'(Bbm) << 6)); end
    @(negedge cck); bus1.rga = 8'hFA;
    @(negedge cck); bus1.rga = 8'h00;
    checks++; if (bus1.drdo !== (16'h002F | (16'(Bbm) << 6)) || bus1.drd_oe !== 1'b1) begin
      failures++;
      $display("FAIL config16 got %h oe=%b want %h 1", bus1.drdo, bus1.drd_oe,
               16'h002F | (16'(Bbm) << 6)); end
    @(negedge cck);
    checks++; if (bus1.drdo !== 16'h0000 || bus1.drd_oe !== 1'b0) begin failures++;
      $display("FAIL config16_drop got %h oe=%b want 0000 0", bus1.drdo, bus1.drd_oe); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d, d2; logic oe, oe2;
    @(negedge cck); bus0.rga = 8'hFA;
    @(negedge cck); bus0.rga = 8'hFB;
    checks++; if (bus0.drdo !== (16'h0007 | (16'(Bbm) << 6)) || bus0.drd_oe !== 1'b1) begin
      failures++; $display("FAIL b2b_config got %h oe=%b", bus0.drdo, bus0.drd_oe); end
    @(negedge cck); bus0.rga = 8'hF8;
    checks++; if (bus0.drdo !== 16'h0000 || bus0.drd_oe !== 1'b1) begin failures++;
      $display("FAIL b2b_status got %h oe=%b want 0000 1", bus0.drdo, bus0.drd_oe); end
    @(negedge cck); bus0.rga = 8'hFB; bus0.drdi = 16'h0042;
    checks++; if (bus0.drd_oe !== 1'b0) begin failures++;
      $display("FAIL b2b_write_oe got %b want 0", bus0.drd_oe); end
    @(negedge cck); bus0.rga = 8'h00; bus0.drdi = 16'h0000;
    checks++; if (bus0.drdo !== 16'h0000 || bus0.drd_oe !== 1'b1) begin failures++;
      $display("FAIL b2b_prewrite got %h oe=%b want 0000 1", bus0.drdo, bus0.drd_oe); end
    idle(3);
    rd(8'hFB, d, oe, d2, oe2);
    checks++; if (d !== 16'h0842 || bus0.banksel !== 8'hEF) begin failures++;
      $display("FAIL b2b_post got status=%h sel=%h want 0842 ef", d, bus0.banksel); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] d, d2; logic oe, oe2;
    wr(16'h0000);
    wr(16'h0042);
    checks++; if (bus0.busy !== Bbm) begin failures++;
      $display("FAIL mid_busy got %b want %b", bus0.busy, Bbm); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus0.banksel !== 8'hFF || bus0.busy !== 1'b0 || bus0.led !== 4'b0010) begin
      failures++;
      $display("FAIL async_reset got sel=%h busy=%b led=%b want ff 0 0010", bus0.banksel,
               bus0.busy, bus0.led); end
    @(negedge cck); rst_n = 1'b1;
    idle(3);
    checks++; if (bus0.banksel !== 8'hFF) begin failures++;
      $display("FAIL post_reset_sel got %h want ff", bus0.banksel); end
    rd(8'hFB, d, oe, d2, oe2);
    checks++; if (d !== 16'h0000) begin failures++;
      $display("FAIL post_reset_status got %h want 0000", d); end
    @(negedge cck); bus0.rga = 8'hFB;
    @(negedge cck); bus0.rga = 8'h00;
    rst_n = 1'b0;
    #1;
    checks++; if (bus0.drd_oe !== 1'b0 || bus0.drdo !== 16'h0000) begin failures++;
      $display("FAIL reset_mid_read got %h oe=%b want 0000 0", bus0.drdo, bus0.drd_oe); end
    @(negedge cck); rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    test_reset();
    test_connect();
    test_switch();
    test_lock();
    test_range();
    test_config();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
